dtc_down_counter16: RTL

- 16-bit loadable down counter with a down terminal count flag (DTC). It is the counting-down counterpart of the lab counter's up/UTC path.
- Loads from switches. Decrements either continuously (run level gated by a tick strobe) or one step per button press (edge-detected).
- Sits between the button/switch inputs and the seven-segment display mux in the lab top level.
- DTC drives the dp/LED indicator and the chaining input of any higher counter stage.

---
 rtl/lab4_pkg.sv | 9 +
 rtl/edge_detector.sv | 26 ++
 rtl/dtc_down_counter16.sv | 76 +++++++
 3 files changed

// File: rtl/lab4_pkg.sv
// Shared constants for the lab counter datapath.
package lab4_pkg;

    localparam int WIDTH_DEFAULT = 16;

    localparam logic [WIDTH_DEFAULT-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH_DEFAULT-1:0] CNT_ONES = '1;

endpackage : lab4_pkg

// File: rtl/edge_detector.sv
// Two-flop synchronizer for a raw button followed by a rising-edge pulse.
// A held button produces a single one-cycle pulse.
module edge_detector (
    input  logic clkin,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic s1_reg;
    logic s2_reg;

    // Synchronize the asynchronous input; s2 is the delayed copy for edge detection.
    always_ff @(posedge clkin) begin
        if (reset) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= in;
            s2_reg <= s1_reg;
        end
    end

    assign pulse = s1_reg & ~s2_reg;

endmodule : edge_detector

// File: rtl/dtc_down_counter16.sv
// Loadable down counter with terminal-count flag (dtc) and a registered
// one-cycle pulse when a decrement reaches zero.
module dtc_down_counter16
    import lab4_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEFAULT,
    parameter bit STOP_AT_ZERO = 1'b0
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    input  logic             run,
    input  logic             tick,
    input  logic             step_btn,
    output logic [WIDTH-1:0] q,
    output logic             dtc,
    output logic             dtc_pulse,
    output logic             busy
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             dtc_pulse_reg;
    logic             dtc_pulse_next;
    logic             step_edge;
    logic             dec;
    logic             q_is_zero;
    logic             q_is_one;

    edge_detector u_step_edge (
        .clkin (clkin),
        .reset (reset),
        .in    (step_btn),
        .pulse (step_edge)
    );

    // Both sources together still count as a single decrement.
    assign dec       = (run & tick) | step_edge;
    assign q_is_zero = (q_reg == '0);
    assign q_is_one  = (q_reg == WIDTH'(1));

    // Next-state mux: load beats decrement beats hold.
    always_comb begin
        q_next         = q_reg;
        dtc_pulse_next = 1'b0;
        if (ld) begin
            q_next = din;
        end else if (dec) begin
            dtc_pulse_next = q_is_one;
            if (!q_is_zero) begin
                q_next = q_reg - WIDTH'(1);
            end else if (!STOP_AT_ZERO) begin
                q_next = '1;
            end
        end
    end

    // Count register and terminal-count pulse register.
    always_ff @(posedge clkin) begin
        if (reset) begin
            q_reg         <= '0;
            dtc_pulse_reg <= 1'b0;
        end else begin
            q_reg         <= q_next;
            dtc_pulse_reg <= dtc_pulse_next;
        end
    end

    assign q         = q_reg;
    assign dtc       = q_is_zero;
    assign dtc_pulse = dtc_pulse_reg;
    // A wrapping counter never runs out of work; a saturating one stops at zero.
    assign busy      = run & (!STOP_AT_ZERO | !q_is_zero);

endmodule : dtc_down_counter16
